// File: rtl/stopwatch_pkg.sv
// Shared stopwatch definitions: FSM state codes,
// default moduli and display-facing counter widths.
package stopwatch_pkg;

  localparam logic [1:0] ST_STOP  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_CLEAR = 2'd2;

  localparam int MSEC_MOD = 100;
  localparam int SEC_MOD  = 60;
  localparam int MIN_MOD  = 60;
  localparam int HOUR_MOD = 24;

  localparam int MSEC_W = 7;
  localparam int SEC_W  = 6;
  localparam int MIN_W  = 6;
  localparam int HOUR_W = 5;

  typedef struct packed {
    logic [MSEC_W-1:0] msec;
    logic [SEC_W-1:0]  sec;
    logic [MIN_W-1:0]  min;
    logic [HOUR_W-1:0] hour;
  } sw_time_t;

endpackage

// File: rtl/stopwatch_tick_gen.sv
// Clock divider producing one-cycle ticks every DIV enabled cycles.
// Holding i_en low freezes the phase so a resume keeps its place.
module stopwatch_tick_gen #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] div_cnt;
  logic          at_last;

  assign at_last = (div_cnt == LAST);
  assign o_tick  = i_en && at_last;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
    end else if (i_clr) begin
      div_cnt <= '0;
    end else if (i_en) begin
      div_cnt <= at_last ? '0 : div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/stopwatch_datapath.sv
// Stopwatch time base: STOP/RUN/CLEAR control plus cascaded
// centisecond/second/minute/hour counters for the FND display.
module stopwatch_datapath
  import stopwatch_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int TICK_HZ  = 100,
  parameter int MSEC_MAX = MSEC_MOD,
  parameter int SEC_MAX  = SEC_MOD,
  parameter int MIN_MAX  = MIN_MOD,
  parameter int HOUR_MAX = HOUR_MOD
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_run_stop,
  input  logic              i_clear,
  output logic [MSEC_W-1:0] o_msec,
  output logic [SEC_W-1:0]  o_sec,
  output logic [MIN_W-1:0]  o_min,
  output logic [HOUR_W-1:0] o_hour,
  output logic              o_running
);

  localparam int DIV = CLK_FREQ / TICK_HZ;

  localparam logic [MSEC_W-1:0] MSEC_LAST = MSEC_W'(MSEC_MAX - 1);
  localparam logic [SEC_W-1:0]  SEC_LAST  = SEC_W'(SEC_MAX - 1);
  localparam logic [MIN_W-1:0]  MIN_LAST  = MIN_W'(MIN_MAX - 1);
  localparam logic [HOUR_W-1:0] HOUR_LAST = HOUR_W'(HOUR_MAX - 1);

  logic [1:0] state;
  logic [1:0] state_nxt;
  sw_time_t   cnt;
  logic       running;
  logic       tick;
  logic       is_stop;
  logic       is_run;
  logic       is_clr;
  logic       msec_wrap;
  logic       sec_wrap;
  logic       min_wrap;
  logic       hour_wrap;

  assign is_stop = (state == ST_STOP);
  assign is_run  = (state == ST_RUN);
  assign is_clr  = (state == ST_CLEAR);

  stopwatch_tick_gen #(
    .DIV (DIV)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .i_en   (is_run),
    .i_clr  (is_clr),
    .o_tick (tick)
  );

  // Arms are mutually exclusive; clear wins over run in STOP.
  always_comb begin
    state_nxt = (is_stop || is_run) ? state : ST_STOP;
    unique case (1'b1)
      is_stop && i_clear:                state_nxt = ST_CLEAR;
      is_stop && !i_clear && i_run_stop: state_nxt = ST_RUN;
      is_run && i_run_stop:              state_nxt = ST_STOP;
      is_clr:                            state_nxt = ST_STOP;
      default: ;
    endcase
  end

  assign msec_wrap = (cnt.msec == MSEC_LAST);
  assign sec_wrap  = (cnt.sec == SEC_LAST);
  assign min_wrap  = (cnt.min == MIN_LAST);
  assign hour_wrap = (cnt.hour == HOUR_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_STOP;
      running <= 1'b0;
      cnt     <= '0;
    end else begin
      state   <= state_nxt;
      running <= (state_nxt == ST_RUN);
      if (is_clr) begin
        cnt <= '0;
      end else if (tick) begin
        cnt.msec <= msec_wrap ? '0 : cnt.msec + 1'b1;
        if (msec_wrap) begin
          cnt.sec <= sec_wrap ? '0 : cnt.sec + 1'b1;
          if (sec_wrap) begin
            cnt.min <= min_wrap ? '0 : cnt.min + 1'b1;
            if (min_wrap) begin
              cnt.hour <= hour_wrap ? '0 : cnt.hour + 1'b1;
            end
          end
        end
      end
    end
  end

  assign o_msec    = cnt.msec;
  assign o_sec     = cnt.sec;
  assign o_min     = cnt.min;
  assign o_hour    = cnt.hour;
  assign o_running = running;

endmodule

// File: tb/tb_stopwatch_datapath.sv
// Bench for stopwatch_datapath: a DIV=10 instance and a tiny-moduli
// DIV=1 instance, checked against an elapsed-tick model each cycle.
module tb_stopwatch_datapath;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic a_rs = 1'b0, a_cl = 1'b0;
  logic b_rs = 1'b0, b_cl = 1'b0;
  logic armed = 1'b0;

  logic [6:0] a_msec, b_msec;
  logic [5:0] a_sec, b_sec;
  logic [5:0] a_min, b_min;
  logic [4:0] a_hour, b_hour;
  logic       a_running, b_running;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  stopwatch_datapath #(
    .CLK_FREQ (1000),
    .TICK_HZ  (100)
  ) dut_a (
    .clk        (clk),
    .reset      (reset),
    .i_run_stop (a_rs),
    .i_clear    (a_cl),
    .o_msec     (a_msec),
    .o_sec      (a_sec),
    .o_min      (a_min),
    .o_hour     (a_hour),
    .o_running  (a_running)
  );

  stopwatch_datapath #(
    .CLK_FREQ (100),
    .TICK_HZ  (100),
    .MSEC_MAX (4),
    .SEC_MAX  (3),
    .MIN_MAX  (2),
    .HOUR_MAX (2)
  ) dut_b (
    .clk        (clk),
    .reset      (reset),
    .i_run_stop (b_rs),
    .i_clear    (b_cl),
    .o_msec     (b_msec),
    .o_sec      (b_sec),
    .o_min      (b_min),
    .o_hour     (b_hour),
    .o_running  (b_running)
  );

  // Model: mode (0 idle, 1 counting, 2 zeroing), cycle phase,
  // and total ticks elapsed; outputs are T split by the moduli.
  int     dv[2] = '{10, 1};
  int     mm[2] = '{100, 4};
  int     sm[2] = '{60, 3};
  int     nm[2] = '{60, 2};
  int     hm[2] = '{24, 2};
  int     m_mode[2] = '{0, 0};
  int     m_ph[2] = '{0, 0};
  longint m_t[2] = '{0, 0};

  function automatic void mstep(int k, logic rs, logic cl);
    case (m_mode[k])
      0: begin
        if (cl) m_mode[k] = 2;
        else if (rs) m_mode[k] = 1;
      end
      1: begin
        m_ph[k] = m_ph[k] + 1;
        if (m_ph[k] == dv[k]) begin
          m_ph[k] = 0;
          m_t[k] = m_t[k] + 1;
        end
        if (rs) m_mode[k] = 0;
      end
      default: begin
        m_t[k] = 0;
        m_ph[k] = 0;
        m_mode[k] = 0;
      end
    endcase
  endfunction

  function automatic int expv(int k, int f);
    longint t = m_t[k];
    case (f)
      0: return int'(t % mm[k]);
      1: return int'((t / mm[k]) % sm[k]);
      2: return int'((t / (mm[k] * sm[k])) % nm[k]);
      3: return int'((t / (mm[k] * sm[k] * nm[k])) % hm[k]);
      default: return (m_mode[k] == 1) ? 1 : 0;
    endcase
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < 2; k++) begin
        m_mode[k] = 0;
        m_ph[k] = 0;
        m_t[k] = 0;
      end
    end else begin
      mstep(0, a_rs, a_cl);
      mstep(1, b_rs, b_cl);
    end
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (reset && armed) begin
      check("a_msec", 32'(a_msec), 32'(expv(0, 0)));
      check("a_sec", 32'(a_sec), 32'(expv(0, 1)));
      check("a_min", 32'(a_min), 32'(expv(0, 2)));
      check("a_hour", 32'(a_hour), 32'(expv(0, 3)));
      check("a_running", 32'(a_running), 32'(expv(0, 4)));
      check("b_msec", 32'(b_msec), 32'(expv(1, 0)));
      check("b_sec", 32'(b_sec), 32'(expv(1, 1)));
      check("b_min", 32'(b_min), 32'(expv(1, 2)));
      check("b_hour", 32'(b_hour), 32'(expv(1, 3)));
      check("b_running", 32'(b_running), 32'(expv(1, 4)));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_a(input logic rs, input logic cl);
    a_rs = rs;
    a_cl = cl;
    @(negedge clk);
    a_rs = 1'b0;
    a_cl = 1'b0;
  endtask

  task automatic pulse_b(input logic rs, input logic cl);
    b_rs = rs;
    b_cl = cl;
    @(negedge clk);
    b_rs = 1'b0;
    b_cl = 1'b0;
  endtask

  initial begin
    cyc(3);
    reset = 1'b1;
    armed = 1'b1;
    cyc(5);
    check("idle_msec", 32'(a_msec), 0);
    check("idle_run", 32'(a_running), 0);

    // full rollover on the tiny-moduli instance
    pulse_b(1'b1, 1'b0);
    cyc(47);
    check("wrap47_msec", 32'(b_msec), 3);
    check("wrap47_sec", 32'(b_sec), 2);
    check("wrap47_min", 32'(b_min), 1);
    check("wrap47_hour", 32'(b_hour), 1);
    cyc(1);
    check("wrap48_msec", 32'(b_msec), 0);
    check("wrap48_sec", 32'(b_sec), 0);
    check("wrap48_min", 32'(b_min), 0);
    check("wrap48_hour", 32'(b_hour), 0);

    pulse_a(1'b1, 1'b0);
    check("run_next", 32'(a_running), 1);
    cyc(9);
    check("run9_msec", 32'(a_msec), 0);
    cyc(1);
    check("run10_msec", 32'(a_msec), 1);
    cyc(990);
    check("run1000_sec", 32'(a_sec), 1);
    check("run1000_msec", 32'(a_msec), 0);
    pulse_a(1'b1, 1'b0);
    pulse_a(1'b0, 1'b1);
    cyc(1);
    check("clr_sec", 32'(a_sec), 0);

    // stop mid-period, resume keeps the phase
    pulse_a(1'b1, 1'b0);
    cyc(14);
    pulse_a(1'b1, 1'b0);
    check("ph_stop_msec", 32'(a_msec), 1);
    check("ph_stop_run", 32'(a_running), 0);
    cyc(50);
    check("ph_hold_msec", 32'(a_msec), 1);
    pulse_a(1'b1, 1'b0);
    cyc(4);
    check("ph_res4_msec", 32'(a_msec), 1);
    cyc(1);
    check("ph_res5_msec", 32'(a_msec), 2);

    pulse_a(1'b0, 1'b1);
    check("clr_in_run", 32'(a_running), 1);
    cyc(20);
    check("clr_ign_run", 32'(a_running), 1);
    pulse_a(1'b1, 1'b0);
    pulse_a(1'b0, 1'b1);
    cyc(1);

    // stop lands exactly on a tick edge
    pulse_a(1'b1, 1'b0);
    cyc(369);
    check("pre37_msec", 32'(a_msec), 36);
    pulse_a(1'b1, 1'b0);
    check("tick_stop_msec", 32'(a_msec), 37);
    check("tick_stop_run", 32'(a_running), 0);
    pulse_a(1'b0, 1'b1);
    check("in_clear_msec", 32'(a_msec), 37);
    cyc(1);
    check("cleared_msec", 32'(a_msec), 0);

    pulse_a(1'b1, 1'b0);
    cyc(9);
    pulse_a(1'b1, 1'b0);
    check("tstop_msec", 32'(a_msec), 1);
    pulse_a(1'b1, 1'b0);
    cyc(9);
    check("tres9_msec", 32'(a_msec), 1);
    cyc(1);
    check("tres10_msec", 32'(a_msec), 2);
    pulse_a(1'b1, 1'b0);

    pulse_a(1'b1, 1'b1);
    check("both_run", 32'(a_running), 0);
    cyc(1);
    check("both_msec", 32'(a_msec), 0);
    check("both_run2", 32'(a_running), 0);

    // asynchronous reset between clock edges
    pulse_a(1'b1, 1'b0);
    cyc(23);
    #2 reset = 1'b0;
    #1;
    check("arst_a_msec", 32'(a_msec), 0);
    check("arst_a_sec", 32'(a_sec), 0);
    check("arst_a_run", 32'(a_running), 0);
    check("arst_b_msec", 32'(b_msec), 0);
    check("arst_b_run", 32'(b_running), 0);
    @(negedge clk);
    reset = 1'b1;
    cyc(5);
    check("post_arst_msec", 32'(a_msec), 0);
    check("post_arst_run", 32'(a_running), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
